ps2_rx_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver with debounced clock sampling, frame validation, scan-code prefix decoding (E0 extended, F0 break) and a first-word-fall-through output FIFO.
Sits between the PS/2 pins and the display/LED assignment FSM.
Replaces the single-byte receiver: bytes are no longer lost when the consumer is slow, and bad frames are reported.

---
 rtl/ps2_rx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 keyboard receiver. Synchronises and debounces the PS/2
//               clock/data pins, deserialises 11-bit frames, validates odd
//               parity and the stop bit, optionally folds E0/F0 prefixes into
//               {ext, brk} flags, and queues the results in a first-word-
//               fall-through FIFO.
//               Optional macro PS2_TIMEOUT_EN: abort a stalled frame after
//               TIMEOUT_CYCLES clk cycles without a PS/2 clock falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int FILTER_LEN      = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DECODE_PREFIX   = 1,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ps2_c,
  input  logic                       ps2_d,
  input  logic                       rx_en,
  input  logic                       rd_en,
  output logic [9:0]                 dout,
  output logic                       vacio,
  output logic                       lleno,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       overflow,
  output logic                       parity_err
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int FCNT_W = $clog2(FILTER_LEN);
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;

  // ---------------------------------------------------------------- inputs
  logic c_meta_q, c_sync_q, d_meta_q, d_sync_q;

  // Two-flop synchronisers for both asynchronous PS/2 pins
  always_ff @(posedge clk) begin
    if (reset) begin
      c_meta_q <= 1'b0;
      c_sync_q <= 1'b0;
      d_meta_q <= 1'b0;
      d_sync_q <= 1'b0;
    end else begin
      c_meta_q <= ps2_c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2_d;
      d_sync_q <= d_meta_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive opposite samples
  logic              filt_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              tick_q;
  logic              filt_flip;

  assign filt_flip = (c_sync_q != filt_q) && (fcnt_q == FCNT_W'(FILTER_LEN - 1));

  // Debounce counter, filtered clock and falling-edge tick
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= filt_flip & filt_q;
      if ((c_sync_q == filt_q) || filt_flip) fcnt_q <= '0;
      else                                   fcnt_q <= fcnt_q + 1'b1;
      if (filt_flip) filt_q <= ~filt_q;
    end
  end

  // -------------------------------------------------------------- receiver
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [9:0] shift_q, shift_d;   // {stop, parity, data[7:0]}
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       push;
  logic [9:0] push_data;
  logic       tmo_abort;
  logic       frame_ok;

  // Odd parity over data+parity, and a high stop bit
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);

`ifdef PS2_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  assign tmo_abort = (state_q == S_DATA) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  // Idle-time counter inside a frame, restarted by every clock tick
  always_ff @(posedge clk) begin
    if (reset || (state_q != S_DATA) || tick_q || tmo_abort) tmo_q <= '0;
    else                                                    tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_abort = 1'b0;
`endif

  // Receiver state register and frame datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
    end
  end

  // Next-state, frame validation and prefix decode
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    push       = 1'b0;
    push_data  = '0;
    parity_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick_q && rx_en && !d_sync_q) begin
          state_d  = S_DATA;
          bitcnt_d = 4'd9;
        end
      end
      S_DATA: begin
        if (tick_q) begin
          shift_d = {d_sync_q, shift_q[9:1]};
          if (bitcnt_q == 4'd0) state_d = S_CHECK;
          else                  bitcnt_d = bitcnt_q - 4'd1;
        end else if (tmo_abort) begin
          state_d    = S_IDLE;
          parity_err = 1'b1;
          ext_d      = 1'b0;
          brk_d      = 1'b0;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (!frame_ok) begin
          parity_err = 1'b1;
          ext_d      = 1'b0;
          brk_d      = 1'b0;
        end else if (DECODE_PREFIX != 0) begin
          if (shift_q[7:0] == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q[7:0] == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {ext_q, brk_q, shift_q[7:0]};
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end
        end else begin
          push      = 1'b1;
          push_data = {2'b00, shift_q[7:0]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ FIFO
  logic [9:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       ovf_q;
  logic                       do_pop, do_push;

  assign vacio    = (count_q == '0);
  assign lleno    = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign dout     = vacio ? 10'd0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign do_pop  = rd_en & ~vacio;
  assign do_push = push & (~lleno | do_pop);

  // Circular buffer storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && lleno && !do_pop) ovf_q <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_fifo
// Description : Scoreboard bench for ps2_rx_fifo. Frames are generated on the
//               PS/2 pins; a reference model of the decode/queue rules pushes
//               expected entries, and a monitor pops and compares whenever the
//               DUT hands out its head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int FILTER_LEN = 8;
  localparam int LOG2       = 4;
  localparam int DEPTH      = 16;
  localparam int HALF       = 15;
  localparam int TMO        = 1000;
  // Pin fall -> 2 sync flops -> FILTER_LEN samples -> tick -> +2 cycles visible
  localparam int PUSH_EDGE  = 2 + FILTER_LEN + 2;

  logic            clk    = 1'b0;
  logic            reset  = 1'b1;
  logic            ps2_c  = 1'b1;
  logic            ps2_d  = 1'b1;
  logic            rx_en  = 1'b1;
  logic            rd_en  = 1'b0;
  logic [9:0]      dout;
  logic            vacio, lleno, overflow, parity_err;
  logic [LOG2:0]   count;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN      (FILTER_LEN),
    .FIFO_DEPTH_LOG2 (LOG2),
    .DECODE_PREFIX   (1),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_c      (ps2_c),
    .ps2_d      (ps2_d),
    .rx_en      (rx_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .vacio      (vacio),
    .lleno      (lleno),
    .count      (count),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         exp_perr = 0;
  int         seen_perr = 0;
  logic [9:0] exp_q[$];
  bit         m_ext = 1'b0, m_brk = 1'b0, m_ovf = 1'b0;
  bit         rd_auto = 1'b0;
  bit         rd_req  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what a received frame means at the consumer side
  task automatic model_frame(input logic [7:0] code, input bit ok, input bit pop_same_cycle);
    if (!ok) begin
      exp_perr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH || pop_same_cycle) exp_q.push_back({m_ext, m_brk, code});
      else                                         m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Single driver of rd_en: random reads or the directed request
  always @(posedge clk) begin
    #1;
    if (rd_auto) rd_en = ($urandom_range(0, 3) == 0);
    else         rd_en = rd_req;
  end

  // Monitor: count parity_err cycles, compare each popped head entry
  always @(negedge clk) begin
    logic [9:0] e;
    if (parity_err === 1'b1) seen_perr++;
    if (!reset && rd_en && !vacio) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no entry", dout);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", dout, e);
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_count"}, count, exp_q.size());
    check({tag, "_vacio"}, vacio, exp_q.size() == 0);
    check({tag, "_lleno"}, lleno, exp_q.size() == DEPTH);
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_perr_cycles"}, seen_perr, exp_perr);
    if (exp_q.size() > 0) check({tag, "_head"}, dout, exp_q[0]);
    else                  check({tag, "_dout_empty"}, dout, 0);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    repeat (FILTER_LEN + 6) @(negedge clk);
  endtask

  task automatic pop_n(input int n);
    repeat (n) begin
      @(negedge clk) rd_req = 1'b1;
      @(negedge clk) rd_req = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  // Drive one frame (or its first nbits bits) onto the PS/2 pins
  task automatic send_frame(input logic [7:0] code, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int nbits = 11,
                            input bit pop_at_push = 1'b0);
    logic [10:0] bits;
    bit          started;
    bits    = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    started = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2_d = bits[i];
      repeat (HALF) @(posedge clk);
      #1;
      ps2_c = 1'b0;
      if (i == 0) started = rx_en;
      if (i == 10 && started) model_frame(code, !bad_par && !bad_stop, pop_at_push);
      if (i == 10 && pop_at_push) begin
        repeat (PUSH_EDGE - 2) @(posedge clk);
        @(negedge clk) rd_req = 1'b1;
        @(negedge clk) rd_req = 1'b0;
        repeat (HALF - PUSH_EDGE + 1) @(posedge clk);
        #1;
      end else begin
        repeat (HALF) @(posedge clk);
        #1;
      end
      ps2_c = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    #1;
    ps2_d = 1'b1;
  endtask

  initial begin
    #900_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [7:0] code;
    bit         bp, bs;
    int         r;

    do_reset();
    check("rst_dout", dout, 0);
    check("rst_vacio", vacio, 1);
    check("rst_lleno", lleno, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_parity_err", parity_err, 0);

    // Single plain frame
    send_frame(8'h1C);
    check_state("single");
    check("single_dout", dout, 10'h01C);
    pop_n(1);
    check_state("single_popped");

    // Extended break prefixes fold into one entry, then flags clear
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    check_state("ext_brk");
    check("ext_brk_dout", dout, 10'h375);
    send_frame(8'h1C);
    check_state("after_prefix");
    pop_n(2);

    // Bad parity discards the byte and clears the prefix state
    send_frame(8'hE0);
    send_frame(8'h1C, 1'b1);
    check_state("bad_parity");
    send_frame(8'hF0);
    send_frame(8'h1C);
    check_state("brk_after_bad");
    check("brk_after_bad_dout", dout, 10'h11C);
    send_frame(8'h2A, 1'b0, 1'b1);
    check_state("bad_stop");
    pop_n(1);

    // Overflow: 17 frames into a 16-entry FIFO with no reads
    for (int i = 1; i <= 17; i++) send_frame(8'(i));
    check_state("full_ovf");
    check("full_ovf_flag", overflow, 1);
    pop_n(DEPTH);
    check_state("full_drained");

    // Full FIFO, last push coincides with a pop
    do_reset();
    for (int i = 1; i <= 16; i++) send_frame(8'(i));
    send_frame(8'h11, 1'b0, 1'b0, 11, 1'b1);
    check_state("push_pop_full");
    check("push_pop_full_ovf", overflow, 0);
    pop_n(DEPTH);
    check_state("push_pop_drained");

    // Reset mid-frame, then a clean frame
    send_frame(8'h55, 1'b0, 1'b0, 5);
    do_reset();
    send_frame(8'h1C);
    check_state("reset_mid");
    pop_n(1);

    // Frame while disabled is ignored
    rx_en = 1'b0;
    send_frame(8'h22);
    rx_en = 1'b1;
    check_state("rx_disabled");

`ifdef PS2_TIMEOUT_EN
    // Stalled frame aborts after the timeout
    send_frame(8'hF0);
    send_frame(8'h33, 1'b0, 1'b0, 4);
    repeat (1200) @(posedge clk);
    #1;
    exp_perr++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_state("timeout");
    send_frame(8'h1C);
    check_state("after_timeout");
    check("after_timeout_dout", dout, 10'h01C);
    pop_n(1);
`endif

    // Randomised traffic with random concurrent reads
    rd_auto = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      code = 8'hE0;
      else if (r == 1) code = 8'hF0;
      else             code = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      send_frame(code, bp, bs);
    end
    repeat (60) @(posedge clk);
    rd_auto = 1'b0;
    repeat (4) @(negedge clk);
    pop_n(exp_q.size());
    check_state("random_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
